// File: rtl/mem_stage_pkg.sv
// Shared field layouts, encodings and state type for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int EX_MEM_W = 108;
    localparam int MEM_WB_W = 103;
    localparam int EXCEPT_W = 119;

    // Exception flags occupy the top byte of the except bundle; the rest is CSR payload.
    localparam int EXC_FLAG_MSB = 118;
    localparam int EXC_FLAG_LSB = 111;

    // mem_op field positions within the 5-bit mem_op sub-field.
    localparam int MOP_LOAD     = 4;
    localparam int MOP_STORE    = 3;
    localparam int MOP_SIZE_LSB = 1;
    localparam int MOP_UNS      = 0;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_CANCEL = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        gr_we;
        logic [4:0]  rf_waddr;
        logic [31:0] alu_result;
        logic        is_load;
        logic        is_store;
        logic [1:0]  size;
        logic        uns;
    } ex_mem_zip_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        gr_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_wb_zip_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shift the word down to the byte offset, then sign/zero extend.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_value
);

    logic [31:0] w_shifted;
    logic        w_sign_b;
    logic        w_sign_h;

    assign w_shifted = i_rdata >> {i_addr, 3'b000};
    assign w_sign_b  = ~i_unsigned & w_shifted[7];
    assign w_sign_h  = ~i_unsigned & w_shifted[15];

    always_comb begin
        o_value = w_shifted;
        case (i_size)
            SIZE_B:  o_value = {{24{w_sign_b}}, w_shifted[7:0]};
            SIZE_H:  o_value = {{16{w_sign_h}}, w_shifted[15:0]};
            default: o_value = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, tracks the data SRAM response, forms the WB bundle.
// Optional ID bypass output enabled by `define MEM_STAGE_FWD_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                EX_to_MEM,
    input  logic [EX_MEM_W-1:0] EX_to_MEM_zip,
    input  logic [EXCEPT_W-1:0] EX_except_zip,
    output logic                MEM_allowin,
    input  logic                WB_allowin,
    output logic                MEM_to_WB,
    output logic [MEM_WB_W-1:0] MEM_to_WB_zip,
    output logic [EXCEPT_W-1:0] MEM_except_zip,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                flush,
    output logic [38:0]         mem_fwd
);

    mem_state_e    r_state;
    mem_state_e    w_state_nxt;
    logic          r_stage_valid;
    ex_mem_zip_t   r_ex;
    logic [EXCEPT_W-1:0] r_except;
    logic [31:0]   r_rdata;

    ex_mem_zip_t   w_in;
    logic          w_in_exc;
    logic          w_is_mem;
    logic          w_has_exc;
    logic          w_ready_go;
    logic          w_allowin;
    logic          w_capture;
    logic          w_start;
    logic          w_handover;
    logic [31:0]   w_load_src;
    logic [31:0]   w_load_val;
    logic [31:0]   w_wdata;
    mem_wb_zip_t   w_wb;
    logic          w_unused;

    assign w_in      = ex_mem_zip_t'(EX_to_MEM_zip);
    assign w_in_exc  = |EX_except_zip[EXC_FLAG_MSB:EXC_FLAG_LSB];
    assign w_is_mem  = r_ex.is_load | r_ex.is_store;
    assign w_has_exc = |r_except[EXC_FLAG_MSB:EXC_FLAG_LSB];

    // An excepting memory op never issued a request, so it is ready immediately.
    assign w_ready_go = ~w_is_mem | w_has_exc | (r_state == ST_HOLD)
                      | ((r_state == ST_WAIT) & data_sram_data_ok);

    // CANCEL blocks intake so a fresh access cannot consume the stale response.
    assign w_allowin  = (r_state != ST_CANCEL) & (~r_stage_valid | (w_ready_go & WB_allowin));
    assign w_capture  = EX_to_MEM & w_allowin;
    assign w_start    = w_capture & ~flush & (w_in.is_load | w_in.is_store) & ~w_in_exc;
    assign w_handover = r_stage_valid & w_ready_go & WB_allowin & ~flush;

    assign MEM_allowin = w_allowin;
    assign MEM_to_WB   = w_handover;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_sram_data_ok) begin
                    if (w_start)                 w_state_nxt = ST_WAIT;
                    else if (w_handover | flush) w_state_nxt = ST_IDLE;
                    else                         w_state_nxt = ST_HOLD;
                end else if (flush) begin
                    w_state_nxt = ST_CANCEL;
                end
            end
            ST_HOLD: begin
                if (w_start)                 w_state_nxt = ST_WAIT;
                else if (w_handover | flush) w_state_nxt = ST_IDLE;
            end
            ST_CANCEL: begin
                if (data_sram_data_ok) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage_valid <= 1'b0;
            r_ex          <= '0;
            r_except      <= '0;
            r_rdata       <= '0;
        end else begin
            if (flush)           r_stage_valid <= 1'b0;
            else if (w_capture)  r_stage_valid <= 1'b1;
            else if (w_handover) r_stage_valid <= 1'b0;

            if (w_capture) begin
                r_ex     <= w_in;
                r_except <= EX_except_zip;
            end

            if ((r_state == ST_WAIT) && data_sram_data_ok) begin
                r_rdata <= data_sram_rdata;
            end
        end
    end

    // Outside HOLD the live SRAM data is used, which gives the zero-bubble load path.
    assign w_load_src = (r_state == ST_HOLD) ? r_rdata : data_sram_rdata;

    load_align u_load_align (
        .i_rdata    (w_load_src),
        .i_addr     (r_ex.alu_result[1:0]),
        .i_size     (r_ex.size),
        .i_unsigned (r_ex.uns),
        .o_value    (w_load_val)
    );

    assign w_wdata = r_ex.is_load ? w_load_val : r_ex.alu_result;

    always_comb begin
        w_wb          = '0;
        w_wb.valid    = r_stage_valid & ~flush;
        w_wb.pc       = r_ex.pc;
        w_wb.ir       = r_ex.ir;
        w_wb.gr_we    = r_ex.gr_we;
        w_wb.rf_waddr = r_ex.rf_waddr;
        w_wb.rf_wdata = w_wdata;
    end

    assign MEM_to_WB_zip  = w_wb;
    assign MEM_except_zip = r_except;

`ifdef MEM_STAGE_FWD_EN
    assign mem_fwd = {r_stage_valid & r_ex.gr_we,
                      r_stage_valid & r_ex.is_load & ~w_ready_go,
                      r_ex.rf_waddr,
                      w_wdata};
`else
    assign mem_fwd = '0;
`endif

    assign w_unused = r_ex.valid;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized ops against a transaction model.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         ex_v;
    logic [107:0] ex_zip;
    logic [118:0] exc_zip;
    logic         allowin;
    logic         wb_allowin;
    logic         to_wb;
    logic [102:0] wb_zip;
    logic [118:0] mem_exc_zip;
    logic         dok;
    logic [31:0]  rdata;
    logic         flush;
    logic [38:0]  mem_fwd;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    string       cur_op  = "reset";

`ifdef MEM_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .EX_to_MEM         (ex_v),
        .EX_to_MEM_zip     (ex_zip),
        .EX_except_zip     (exc_zip),
        .MEM_allowin       (allowin),
        .WB_allowin        (wb_allowin),
        .MEM_to_WB         (to_wb),
        .MEM_to_WB_zip     (wb_zip),
        .MEM_except_zip    (mem_exc_zip),
        .data_sram_data_ok (dok),
        .data_sram_rdata   (rdata),
        .flush             (flush),
        .mem_fwd           (mem_fwd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: observed %h expected %h", cur_op, tag, obs, exp);
    endtask

    function automatic logic [107:0] mk_zip(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] alu, input logic ld,
                                            input logic st, input logic [1:0] sz,
                                            input logic un);
        return {1'b1, pc, ir, we, wa, alu, ld, st, sz, un};
    endfunction

    // Reference: byte offset selects the lane, size picks how many bytes, sign from top bit.
    function automatic logic [31:0] model_wdata(input logic ld, input logic [1:0] sz,
                                                input logic un, input logic [31:0] alu,
                                                input logic [31:0] rd);
        logic [31:0] v;
        if (!ld) return alu;
        v = rd >> (8 * (alu % 4));
        if (sz == 2'd0) begin
            v = v % 256;
            if (!un && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (!un && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One instruction from capture to handover; inputs change at negedge, checks 1 ns later.
    task automatic run_op(input logic [107:0] z, input logic [118:0] ez, input logic [31:0] rd,
                          input logic [31:0] exp_wd, input int unsigned dly,
                          input int unsigned stall);
        logic         ld, st, we, exc, waiting;
        logic [4:0]   wa;
        logic [102:0] exp_zip;
        ld  = z[4];
        st  = z[3];
        we  = z[42];
        wa  = z[41:37];
        exc = |ez[118:111];
        waiting = (ld | st) & ~exc;
        exp_zip = {1'b1, z[106:37], exp_wd};

        ex_v = 1'b1; ex_zip = z; exc_zip = ez; wb_allowin = 1'b1; dok = 1'b0; flush = 1'b0;
        #1 check("allowin_at_capture", allowin, 1'b1);
        @(negedge clk);
        ex_v = 1'b0; ex_zip = {$urandom, $urandom, $urandom, $urandom};
        if (waiting) begin
            for (int unsigned d = 0; d < dly; d++) begin
                rdata = $urandom;
                #1;
                check("no_wb_while_wait", to_wb, 1'b0);
                check("allowin_while_wait", allowin, 1'b0);
                check("fwd_busy", mem_fwd[38:32], FWD ? {we, ld, wa} : 7'd0);
                @(negedge clk);
            end
            dok = 1'b1; rdata = rd;
        end
        for (int unsigned s = 0; s < stall; s++) begin
            wb_allowin = 1'b0;
            #1;
            check("no_wb_while_stall", to_wb, 1'b0);
            check("allowin_while_stall", allowin, 1'b0);
            @(negedge clk);
            dok = 1'b0;
            if (waiting) rdata = $urandom;
        end
        wb_allowin = 1'b1;
        #1;
        check("to_wb", to_wb, 1'b1);
        if (ld & exc) check("wb_zip_hdr", wb_zip[102:32], exp_zip[102:32]);
        else          check("wb_zip", wb_zip, exp_zip);
        check("except_zip", mem_exc_zip, ez);
        check("allowin_at_handover", allowin, 1'b1);
        check("fwd_hdr", mem_fwd[38:32], FWD ? {we, 1'b0, wa} : 7'd0);
        if (!(ld & exc)) check("fwd_data", mem_fwd[31:0], FWD ? exp_wd : 32'd0);
        @(negedge clk);
        dok = 1'b0;
        #1 check("single_pulse", to_wb, 1'b0);
    endtask

    initial begin
        logic [107:0] z;
        logic [118:0] ez;
        logic [127:0] tmp;
        logic [31:0]  alu, rd, pc;
        logic         ld, st, un;
        logic [1:0]   sz;
        int unsigned  kind;

        rst = 1'b1; ex_v = 1'b0; ex_zip = '0; exc_zip = '0; wb_allowin = 1'b1;
        dok = 1'b0; rdata = '0; flush = 1'b0;
        #1;
        check("rst_allowin", allowin, 1'b1);
        check("rst_to_wb", to_wb, 1'b0);
        check("rst_wb_zip", wb_zip, 103'd0);
        check("rst_exc_zip", mem_exc_zip, 119'd0);
        check("rst_fwd", mem_fwd, 39'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        cur_op = "ld.b";
        run_op(mk_zip(32'h1C00_0010, 32'h2800_0C85, 1'b1, 5'd5, 32'h1000_0003, 1'b1, 1'b0, 2'd0, 1'b0),
               119'h0_1234, 32'h80FF_FF12, 32'hFFFF_FF80, 1, 0);

        cur_op = "ld.hu";
        run_op(mk_zip(32'h1C00_0014, 32'h2A40_0C86, 1'b1, 5'd6, 32'h2000_0002, 1'b1, 1'b0, 2'd1, 1'b1),
               119'h0_5678, 32'h8001_1234, 32'h0000_8001, 0, 0);

        cur_op = "ld.w_hold";
        run_op(mk_zip(32'h1C00_0018, 32'h2880_0C87, 1'b1, 5'd7, 32'h3000_0000, 1'b1, 1'b0, 2'd2, 1'b0),
               119'h0_9ABC, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 3);

        cur_op = "ld.b_exc";
        ez = '0; ez[118:111] = 8'h04; ez[40:0] = 41'h1_2345_6789;
        run_op(mk_zip(32'h1C00_001C, 32'h2800_0C88, 1'b1, 5'd8, 32'h0000_0001, 1'b1, 1'b0, 2'd0, 1'b0),
               ez, 32'h0, 32'h0, 0, 0);

        cur_op = "flush_wait";
        ex_v = 1'b1; ex_zip = mk_zip(32'h1C00_0020, 32'h0, 1'b1, 5'd9, 32'h4000_0000, 1'b1, 1'b0, 2'd2, 1'b0);
        exc_zip = '0; wb_allowin = 1'b1;
        @(negedge clk);
        ex_v = 1'b0; flush = 1'b1;
        #1;
        check("no_wb_on_flush", to_wb, 1'b0);
        check("zip_valid_on_flush", wb_zip[102], 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("allowin_cancel_1", allowin, 1'b0);
        @(negedge clk);
        dok = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        check("allowin_cancel_2", allowin, 1'b0);
        check("no_wb_cancel", to_wb, 1'b0);
        @(negedge clk);
        dok = 1'b0;
        #1;
        check("allowin_after_cancel", allowin, 1'b1);
        check("no_wb_after_cancel", to_wb, 1'b0);

        cur_op = "flush_capture";
        ex_v = 1'b1; flush = 1'b1;
        ex_zip = mk_zip(32'h1C00_0024, 32'h0, 1'b1, 5'd10, 32'h5000_0000, 1'b1, 1'b0, 2'd2, 1'b0);
        @(negedge clk);
        ex_v = 1'b0; flush = 1'b0; dok = 1'b1;
        #1;
        check("discarded_no_wb", to_wb, 1'b0);
        check("discarded_allowin", allowin, 1'b1);
        check("discarded_zip_valid", wb_zip[102], 1'b0);
        @(negedge clk);
        dok = 1'b0;

        cur_op = "add.w_b2b";
        for (int i = 0; i < 5; i++) begin
            ex_v = 1'b1; ez = '0; ez[31:0] = 32'(i + 100); exc_zip = ez;
            ex_zip = mk_zip(32'h1C00_0100 + 32'(4 * i), 32'h0010_1800, 1'b1, 5'(i + 1),
                            32'h1234 + 32'(i), 1'b0, 1'b0, 2'd2, 1'b0);
            #1;
            check("b2b_allowin", allowin, 1'b1);
            if (i > 0) begin
                check("b2b_to_wb", to_wb, 1'b1);
                check("b2b_wdata", wb_zip[31:0], 32'h1234 + 32'(i - 1));
                check("b2b_waddr", wb_zip[36:32], 5'(i));
            end else begin
                check("b2b_first_idle", to_wb, 1'b0);
            end
            @(negedge clk);
        end
        ex_v = 1'b0;
        #1;
        check("b2b_last_to_wb", to_wb, 1'b1);
        check("b2b_last_wdata", wb_zip[31:0], 32'h1238);
        @(negedge clk);
        #1 check("b2b_drained", to_wb, 1'b0);

        cur_op = "rst_mid_wait";
        ex_v = 1'b1; exc_zip = 119'h7_7777;
        ex_zip = mk_zip(32'h1C00_0200, 32'h0, 1'b1, 5'd11, 32'h6000_0000, 1'b1, 1'b0, 2'd2, 1'b0);
        @(negedge clk);
        ex_v = 1'b0;
        #1 check("waiting_before_rst", allowin, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_allowin", allowin, 1'b1);
        check("async_to_wb", to_wb, 1'b0);
        check("async_wb_zip", wb_zip, 103'd0);
        check("async_exc_zip", mem_exc_zip, 119'd0);
        check("async_fwd", mem_fwd, 39'd0);
        @(negedge clk);
        rst = 1'b0; dok = 1'b1; rdata = 32'h1111_2222; wb_allowin = 1'b1;
        #1;
        check("late_dok_no_wb", to_wb, 1'b0);
        check("late_dok_allowin", allowin, 1'b1);
        @(negedge clk);
        dok = 1'b0;
        #1 check("late_dok_after", to_wb, 1'b0);

        for (int n = 0; n < 40; n++) begin
            cur_op = $sformatf("rand%0d", n);
            kind = $urandom_range(0, 2);
            ld  = (kind == 1);
            st  = (kind == 2);
            sz  = ld ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            un  = 1'($urandom_range(0, 1));
            alu = $urandom;
            pc  = $urandom;
            rd  = $urandom;
            z   = mk_zip(pc, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                         alu, ld, st, sz, un);
            tmp = {$urandom, $urandom, $urandom, $urandom};
            ez  = tmp[118:0];
            ez[118:111] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_op(z, ez, rd, model_wdata(ld, sz, un, alu, rd),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have these ports; clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- EX_to_MEM  in  1  EX hands over one instruction this cycle
- EX_to_MEM_zip  in  108  {valid, pc[31:0], IR[31:0], gr_we, rf_waddr[4:0], alu_result[31:0], mem_op[4:0]}; mem_op = {is_load, is_store, size[1:0] (0=B,1=H,2=W), unsigned}
- EX_except_zip  in  119  CSR and exception bundle, same layout as MEM_except_zip
- MEM_allowin  out  1  stage can accept a new instruction
- WB_allowin  in  1  downstream accept
- MEM_to_WB  out  1  handover pulse to WB
- MEM_to_WB_zip  out  103  {valid, pc, IR, gr_we, rf_waddr, rf_wdata}
- MEM_except_zip  out  119  registered EX_except_zip, passed through unchanged
- data_sram_data_ok  in  1  load/store response strobe
- data_sram_rdata  in  32  load response data
- flush  in  1  wb_ex | ertn_flush from WB
- mem_fwd  out  39  {fwd_valid, fwd_busy, rf_waddr[4:0], rf_wdata[31:0]}, for ID bypass

Function
REQ-002 Capture both zips on a clock edge where EX_to_MEM=1; EX_to_MEM=1 while MEM_allowin=0 is a protocol error and needs no handling.
REQ-003 stage_valid SHALL set on capture and clear on a handover or flush.
REQ-004 ready_go SHALL be 1 when any of these holds: non-memory instruction; memory instruction whose response has arrived; memory instruction with any exception bit set in the except zip (no response expected).
REQ-005 MEM_allowin SHALL equal ~stage_valid | (ready_go & WB_allowin).
REQ-006 MEM_to_WB SHALL equal stage_valid & ready_go & WB_allowin & ~flush.
REQ-007 Response FSM states: IDLE, WAIT, HOLD, CANCEL.
- IDLE->WAIT: capture of a memory instruction with no exception.
- WAIT->HOLD: data_sram_data_ok=1; latch rdata.
- WAIT->CANCEL: flush=1 before data_ok.
- HOLD->IDLE: handover.
- CANCEL->IDLE: data_ok=1; the response is discarded.
REQ-008 data_ok in IDLE or HOLD SHALL be ignored.
REQ-009 While in CANCEL, MEM_allowin SHALL be 0, so a new access cannot pair with a stale response.
REQ-010 rf_wdata rules:
- load: rdata shifted right by 8*alu_result[1:0], then sign- or zero-extended to 32 bits per size/unsigned.
- otherwise: alu_result.
REQ-011 A load whose data_ok arrives in the same cycle as WB_allowin=1 SHALL hand over in that cycle, using data_sram_rdata directly (zero-bubble path).
REQ-012 MEM_to_WB_zip.valid SHALL equal stage_valid & ~flush at handover.
REQ-013 Flush coinciding with capture SHALL discard the captured instruction.

Reset
REQ-014 rst SHALL asynchronously set the following, independent of clk:
- FSM=IDLE, stage_valid=0, zips=0, latched rdata=0
- so MEM_allowin=1, MEM_to_WB=0, mem_fwd=0
REQ-015 Reset during WAIT or CANCEL SHALL abandon the outstanding response without a handover.

Configuration
REQ-016 Macro MEM_STAGE_FWD_EN:
- Defined: mem_fwd.fwd_valid = stage_valid & gr_we; fwd_busy = load not yet ready; rf_wdata is live.
- Undefined: mem_fwd is tied to 0 and ID relies on interlock only.

Structure
REQ-017 These belong in shared macros.h: zip widths (EX_MEM 108, MEM_WB 103, EXCEPT 119), mem_op field positions, size encodings and FSM state encodings.
REQ-018 Load alignment and extension SHALL be a combinational sub-module, load_align (inputs: rdata, addr[1:0], size, unsigned; output: 32-bit value).

Verification
REQ-019 Directed scenarios:
- ld.b at addr 0x...3, rdata=0x80FF_FF12, data_ok 1 cycle later, WB_allowin=1 -> rf_wdata=0xFFFF_FF80, MEM_to_WB pulses once.
- ld.hu at addr 0x...2, rdata=0x8001_1234 -> rf_wdata=0x0000_8001.
- data_ok arrives while WB_allowin=0 for 3 cycles -> HOLD keeps rdata, MEM_allowin=0, handover on the first WB_allowin=1.
- flush in WAIT, data_ok 2 cycles later -> no MEM_to_WB, MEM_allowin=0 until data_ok, then 1.
- add.w with alu_result=0x1234, back-to-back with EX_to_MEM every cycle -> one handover per cycle with no bubbles.
- rst asserted mid-WAIT between clock edges -> outputs clear immediately; a later data_ok is ignored.
